// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with in/out valid-ready handshake, flags Ofl/Z/N/C and an iterative shift-add multiply (clk, rst, in_valid/in_ready+A,B,Cin,Op,invA,invB,sign -> out_valid/out_ready+Out,Ofl,Z,N,C)
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Z,
  output logic             N,
  output logic             C
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, ma, mb, res, mplier;
  logic [SHW-1:0] sh, cnt;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] mcand, prod, prod_nx, pf;
  logic accept, is_mul, res_ofl, res_c, neg, msgn, mofl;
  assign sa = invA ? ~A : A;
  assign sb = invB ? ~B : B;
  assign sh = sb[SHW-1:0];
  assign sum = {1'b0, sa} + {1'b0, sb} + {{WIDTH{1'b0}}, Cin};
  assign ma = (sign && sa[WIDTH-1]) ? -sa : sa;
  assign mb = (sign && sb[WIDTH-1]) ? -sb : sb;
  assign is_mul = Op == 4'b1100;
  assign out_valid = state == DONE;
  assign in_ready = (state != BUSY) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign Z = Out == '0;
  assign N = Out[WIDTH-1];
  assign prod_nx = mplier[0] ? prod + mcand : prod;
  assign pf = neg ? -prod_nx : prod_nx;
  assign mofl = msgn ? pf[2*WIDTH-1:WIDTH] != {WIDTH{pf[WIDTH-1]}} : pf[2*WIDTH-1:WIDTH] != '0;
  always_comb begin
    res = '0;
    res_ofl = 1'b0;
    res_c = 1'b0;
    case (Op)
      4'b0000: res = (sa << sh) | (sa >> (WIDTH - int'(sh)));
      4'b0001: res = sa << sh;
      4'b0010: res = (sa >> sh) | (sa << (WIDTH - int'(sh)));
      4'b0011: res = sa >> sh;
      4'b0100: res = $signed(sa) >>> sh;
      4'b1000: begin
        res = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_ofl = sign ? (sa[WIDTH-1] == sb[WIDTH-1]) && (sum[WIDTH-1] != sa[WIDTH-1]) : sum[WIDTH];
      end
      4'b1001: res = sa | sb;
      4'b1010: res = sa ^ sb;
      4'b1011: res = sa & sb;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_nx = state;
    if (state == BUSY) state_nx = (cnt == '0) ? DONE : BUSY;
    else if (accept) state_nx = is_mul ? BUSY : DONE;
    else if (out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Out <= '0;
      Ofl <= 1'b0;
      C <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      neg <= 1'b0;
      msgn <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && !is_mul) begin
        Out <= res;
        Ofl <= res_ofl;
        C <= res_c;
      end
      if (accept && is_mul) begin
        mcand <= {{WIDTH{1'b0}}, ma};
        mplier <= mb;
        prod <= '0;
        cnt <= SHW'(WIDTH - 1);
        neg <= sign && (sa[WIDTH-1] ^ sb[WIDTH-1]);
        msgn <= sign;
      end
      if (state == BUSY) begin
        prod <= prod_nx;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= (cnt == '0) ? cnt : cnt - SHW'(1);
        if (cnt == '0) begin
          Out <= pf[WIDTH-1:0];
          Ofl <= mofl;
          C <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=16 and WIDTH=32
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] a = '0, b = '0;
  logic cin = 1'b0, inva = 1'b0, invb = 1'b0, sign = 1'b0;
  logic [3:0] op = '0;
  logic v16 = 1'b0, v32 = 1'b0, r16 = 1'b1, r32 = 1'b1;
  logic ir16, ov16, ofl16, z16, n16, c16;
  logic ir32, ov32, ofl32, z32, n32, c32;
  logic [15:0] out16;
  logic [31:0] out32;
  alu_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .A(a[15:0]), .B(b[15:0]),
    .Cin(cin), .Op(op), .invA(inva), .invB(invb), .sign(sign), .out_valid(ov16), .out_ready(r16),
    .Out(out16), .Ofl(ofl16), .Z(z16), .N(n16), .C(c16));
  alu_pipe #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .A(a), .B(b),
    .Cin(cin), .Op(op), .invA(inva), .invB(invb), .sign(sign), .out_valid(ov32), .out_ready(r32),
    .Out(out32), .Ofl(ofl32), .Z(z32), .N(n32), .C(c32));
  typedef struct packed {logic [31:0] out; logic [3:0] fl;} exp_t;
  typedef struct packed {bit w32; logic [31:0] a, b; logic ci; logic [3:0] op; logic ia, ib, sg; logic [31:0] out; logic [3:0] fl; int lat;} vec_t;
  exp_t sb[$];
  int checks = 0, passed = 0;
  function automatic exp_t model(int w, logic [31:0] av, logic [31:0] bv, logic ci, logic [3:0] o, logic ia, logic ib, logic sg);
    longint unsigned m, x, y, r;
    longint sx, sy, p;
    int s;
    logic of, co;
    m = (64'd1 << w) - 64'd1;
    x = (ia ? ~{32'd0, av} : {32'd0, av}) & m;
    y = (ib ? ~{32'd0, bv} : {32'd0, bv}) & m;
    s = int'(y) & (w - 1);
    r = 0;
    of = 1'b0;
    co = 1'b0;
    case (o)
      4'h0: r = (x << s) | (x >> (w - s));
      4'h1: r = x << s;
      4'h2: r = (x >> s) | (x << (w - s));
      4'h3: r = x >> s;
      4'h4: r = (x >> s) | (x[w-1] ? (m & ~(m >> s)) : 64'd0);
      4'h8: begin
        r = x + y + 64'(ci);
        co = r[w];
        of = sg ? (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]) : co;
      end
      4'h9: r = x | y;
      4'hA: r = x ^ y;
      4'hB: r = x & y;
      4'hC: begin
        if (sg) begin
          sx = x[w-1] ? longint'(x) - (longint'(1) <<< w) : longint'(x);
          sy = y[w-1] ? longint'(y) - (longint'(1) <<< w) : longint'(y);
          p = sx * sy;
          r = p;
          of = (p >= (longint'(1) <<< (w - 1))) || (p < -(longint'(1) <<< (w - 1)));
        end else begin
          r = x * y;
          of = (r >> w) != 0;
        end
      end
      default: r = 0;
    endcase
    r = r & m;
    return exp_t'({r[31:0], of, r == 0, r[w-1], co});
  endfunction
  task automatic issue(bit w32, logic [31:0] av, logic [31:0] bv, logic ci, logic [3:0] o, logic ia, logic ib, logic sg, bit push);
    @(negedge clk);
    a = av; b = bv; cin = ci; op = o; inva = ia; invb = ib; sign = sg;
    if (w32) v32 = 1'b1;
    else v16 = 1'b1;
    if (push) sb.push_back(model(w32 ? 32 : 16, av, bv, ci, o, ia, ib, sg));
    @(posedge clk);
    #1 v16 = 1'b0;
    v32 = 1'b0;
  endtask
  task automatic wait_out(bit w32, output int lat, output logic [31:0] o, output logic [3:0] f, output int busy_ready, output exp_t e);
    lat = 1;
    busy_ready = 0;
    @(negedge clk);
    while (!(w32 ? ov32 : ov16) && lat < 100) begin
      busy_ready += int'(w32 ? ir32 : ir16);
      @(negedge clk);
      lat++;
    end
    o = w32 ? out32 : {16'd0, out16};
    f = w32 ? {ofl32, z32, n32, c32} : {ofl16, z16, n16, c16};
    if (sb.size() > 0) e = sb.pop_front();
    else e = exp_t'({32'hDEAD_BEEF, 4'hF});
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ov16, ir16, out16, ofl16, z16, n16, c16} !== {1'b0, 1'b1, 16'h0, 4'b0100}) $display("FAIL reset16: got %b want %b", {ov16, ir16, out16, ofl16, z16, n16, c16}, {1'b0, 1'b1, 16'h0, 4'b0100});
    else passed++;
    checks++;
    if ({ov32, ir32, out32, ofl32, z32, n32, c32} !== {1'b0, 1'b1, 32'h0, 4'b0100}) $display("FAIL reset32: got %b want %b", {ov32, ir32, out32, ofl32, z32, n32, c32}, {1'b0, 1'b1, 32'h0, 4'b0100});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ir16, ir32, ov16, ov32} !== 4'b1100) $display("FAIL reset_release: got %b want 1100", {ir16, ir32, ov16, ov32});
    else passed++;
  endtask
  task automatic test_directed();
    vec_t tv[25] = '{
      '{1'b0, 32'h7FFF, 32'h0001, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 32'h8000, 4'b1010, 1},
      '{1'b0, 32'hFFFF, 32'h0001, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 32'h0000, 4'b1101, 1},
      '{1'b0, 32'h00FF, 32'h0F0F, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 32'h0FF0, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0004, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0018, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0004, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 32'h0010, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0004, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 32'h1800, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0004, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0800, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0004, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 32'hF800, 4'b0010, 1},
      '{1'b0, 32'h8001, 32'h0014, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0018, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0014, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 32'h1800, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0014, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0800, 4'b0000, 1},
      '{1'b0, 32'h8001, 32'h0014, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 32'hF800, 4'b0010, 1},
      '{1'b0, 32'h0100, 32'h0100, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 32'h0000, 4'b1100, 17},
      '{1'b0, 32'hFFFD, 32'h0005, 1'b0, 4'hC, 1'b0, 1'b0, 1'b1, 32'hFFF1, 4'b0010, 17},
      '{1'b0, 32'hFFFF, 32'hFFFF, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 32'h0000, 4'b0100, 1},
      '{1'b0, 32'h0000, 32'h0001, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 32'h0000, 4'b1101, 1},
      '{1'b0, 32'h1200, 32'hFFFF, 1'b0, 4'h9, 1'b0, 1'b1, 1'b0, 32'h1200, 4'b0000, 1},
      '{1'b0, 32'h0F0F, 32'h00FF, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 32'h000F, 4'b0000, 1},
      '{1'b0, 32'h0001, 32'h0001, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 32'h0003, 4'b0000, 1},
      '{1'b0, 32'h8000, 32'hFFFF, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 32'h7FFF, 4'b1001, 1},
      '{1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b1101, 1},
      '{1'b1, 32'h00010000, 32'h00010000, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b1100, 33},
      '{1'b1, 32'hFFFFFFFD, 32'h00000005, 1'b0, 4'hC, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF1, 4'b0010, 33},
      '{1'b1, 32'h80000001, 32'h00000024, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 32'h18000000, 4'b0000, 1},
      '{1'b1, 32'h80000001, 32'h00000004, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 32'hF8000000, 4'b0010, 1}
    };
    int lat, br;
    logic [31:0] o;
    logic [3:0] f;
    exp_t e;
    foreach (tv[i]) begin
      sb.push_back(exp_t'({tv[i].out, tv[i].fl}));
      issue(tv[i].w32, tv[i].a, tv[i].b, tv[i].ci, tv[i].op, tv[i].ia, tv[i].ib, tv[i].sg, 1'b0);
      wait_out(tv[i].w32, lat, o, f, br, e);
      checks++;
      if (lat !== tv[i].lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tv[i].lat);
      else passed++;
      checks++;
      if (o !== e.out) $display("FAIL dir%0d_out: got %h want %h", i, o, e.out);
      else passed++;
      checks++;
      if (f !== e.fl) $display("FAIL dir%0d_flags(OZNC): got %b want %b", i, f, e.fl);
      else passed++;
      if (tv[i].lat > 1) begin
        checks++;
        if (br !== 0) $display("FAIL dir%0d_busy_in_ready: got %0d high cycles want 0", i, br);
        else passed++;
      end
    end
  endtask
  task automatic test_back_to_back();
    int lat, br;
    logic [31:0] o;
    logic [3:0] f;
    exp_t e;
    r16 = 1'b0;
    sb.push_back(exp_t'({32'h0FF0, 4'b0000}));
    issue(1'b0, 32'h00F0, 32'h0F00, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_out(1'b0, lat, o, f, br, e);
    checks++;
    if ({o, f} !== {e.out, e.fl} || lat !== 1) $display("FAIL b2b_or: got %h/%b lat %0d want %h/%b lat 1", o, f, lat, e.out, e.fl);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ov16, ir16, out16, ofl16, z16, n16, c16} !== {1'b1, 1'b0, 16'h0FF0, 4'b0000}) $display("FAIL b2b_stall%0d: got %b want %b", i, {ov16, ir16, out16, ofl16, z16, n16, c16}, {1'b1, 1'b0, 16'h0FF0, 4'b0000});
      else passed++;
    end
    a = 32'h0FF0; b = 32'h3C3C; cin = 1'b0; op = 4'hB; inva = 1'b0; invb = 1'b0; sign = 1'b0;
    v16 = 1'b1;
    r16 = 1'b1;
    sb.push_back(exp_t'({32'h0C30, 4'b0000}));
    #1 checks++;
    if (ir16 !== 1'b1) $display("FAIL b2b_ready: got %b want 1", ir16);
    else passed++;
    @(posedge clk);
    #1 v16 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({ov16, out16, ofl16, z16, n16, c16} !== {1'b1, e.out[15:0], e.fl}) $display("FAIL b2b_and: got %b want %b", {ov16, out16, ofl16, z16, n16, c16}, {1'b1, e.out[15:0], e.fl});
    else passed++;
    @(negedge clk);
    checks++;
    if (ov16 !== 1'b0) $display("FAIL b2b_drain: got out_valid %b want 0", ov16);
    else passed++;
  endtask
  task automatic test_reset_mid_mul();
    int hits;
    issue(1'b0, 32'h1234, 32'h5678, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 checks++;
    if ({ov16, out16, z16, n16, ir16} !== {1'b0, 16'h0, 1'b1, 1'b0, 1'b1}) $display("FAIL mul_abort: got %b want %b", {ov16, out16, z16, n16, ir16}, {1'b0, 16'h0, 1'b1, 1'b0, 1'b1});
    else passed++;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      hits += int'(ov16);
    end
    checks++;
    if (hits !== 0) $display("FAIL mul_abort_no_result: got %0d valid cycles want 0", hits);
    else passed++;
  endtask
  task automatic test_random();
    int lat, br, want_lat;
    logic [31:0] o, av, bv;
    logic [3:0] f, rop;
    exp_t e;
    bit w;
    for (int i = 0; i < 40; i++) begin
      w = i[0];
      rop = 4'($urandom_range(0, 15));
      av = $urandom;
      bv = $urandom;
      issue(w, av, bv, 1'($urandom), rop, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      wait_out(w, lat, o, f, br, e);
      want_lat = (rop == 4'hC) ? (w ? 33 : 17) : 1;
      checks++;
      if (lat !== want_lat || br !== 0) $display("FAIL rnd%0d_timing: got lat %0d ready %0d want lat %0d ready 0", i, lat, br, want_lat);
      else passed++;
      checks++;
      if ({o, f} !== {e.out, e.fl}) $display("FAIL rnd%0d_op%h: got %h/%b want %h/%b", i, rop, o, f, e.out, e.fl);
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU.
- Adds a valid/ready handshake on input and output, registered results and flags (Ofl, Z, N, C), and a multi-cycle shift-add multiply mode.
- Sits between the decode/register-read stage and writeback; stalls upstream while multiplying or while the output is back-pressured.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in for ADD.
- Op  in  4  operation select (encoding below).
- invA  in  1  invert A before use.
- invB  in  1  invert B before use.
- sign  in  1  1 = two's-complement overflow/multiply semantics.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts result this cycle.
- Out  out  WIDTH  registered result.
- Ofl  out  1  overflow flag.
- Z  out  1  Out == 0.
- N  out  1  Out[WIDTH-1].
- C  out  1  carry-out (ADD only, else 0).

Behaviour:
- Operands: sA = invA ? ~A : A; sB = invB ? ~B : B; both sampled into internal registers on accept.
- Accept: a bundle is accepted when in_valid && in_ready.
  - in_ready = (state != BUSY) && (!out_valid || out_ready).
- Op encoding; shift amount sh = sB[SHW-1:0]:
  - 0000 rotate left by sh.
  - 0001 shift left logical by sh.
  - 0010 rotate right by sh.
  - 0011 shift right logical by sh.
  - 0100 shift right arithmetic by sh.
  - 1000 ADD: sA+sB+Cin, WIDTH+1-bit sum, C = bit WIDTH.
  - 1001 OR, 1010 XOR, 1011 AND.
  - 1100 MUL: low WIDTH bits of product.
  - Undefined codes: Out=0, Ofl=0, C=0, accepted normally.
- Ofl rules:
  - ADD, sign=1: (sA[msb]==sB[msb]) && (sum[msb]!=sA[msb]).
  - ADD, sign=0: carry-out.
  - MUL, sign=0: upper WIDTH bits of the 2·WIDTH product ≠ 0.
  - MUL, sign=1: 2·WIDTH signed product ≠ sign-extension of its low WIDTH bits.
  - All other ops: Ofl=0.
- Z and N are always derived from the registered Out.
- FSM states:
  - IDLE → DONE when a non-MUL bundle is accepted; result registered, out_valid=1 next cycle (latency 1).
  - IDLE/DONE → BUSY when a MUL bundle is accepted.
    - In BUSY: iterative shift-add, one multiplier bit per cycle, counter runs WIDTH-1 down to 0.
    - sign=1: multiply magnitudes, then negate the product if the operand signs differ.
  - BUSY → DONE after WIDTH iterations; out_valid rises the cycle after the last iteration (latency WIDTH+1 from accept).
  - DONE: Out and all flags are held stable while out_valid && !out_ready.
    - out_ready with no new accept → IDLE, out_valid=0.
    - out_ready with a simultaneous accept → back-to-back; the new result replaces the old one the next cycle, no bubble.
- in_ready=0 throughout BUSY; in_valid is ignored there.
- Reset:
  - rst=1 → state IDLE, out_valid=0, Out=0, Ofl=0, C=0 (so Z=1, N=0), counter=0, in_ready=1 the cycle after reset deasserts.
  - Reset mid-multiply aborts the operation; no result is produced.
  - rst has priority over every simultaneous event.
- Out, flags and out_valid change only on clk edges; no combinational path from A/B to Out.

Test Plan:
- WIDTH=16, ADD A=0x7FFF B=0x0001 Cin=0 sign=1 → Out=0x8000, Ofl=1, N=1, C=0, Z=0, out_valid one cycle after accept.
- WIDTH=16, ADD A=0xFFFF B=0x0001 sign=0 → Out=0x0000, Z=1, C=1, Ofl=1; then XOR A=0x00FF B=0x0F0F → 0x0FF0, Z=0, C=0.
- WIDTH=16 shifts with B=0x0004 on A=0x8001:
  - ROL → 0x0018; SRL → 0x0800; SRA → 0xF800; ROR → 0x1800.
  - B=0x0014 uses low 4 bits only → identical results.
- WIDTH=16 MUL:
  - sign=0, A=0x0100 B=0x0100 → Out=0x0000, Ofl=1.
  - sign=1, A=0xFFFD(-3) B=0x0005 → Out=0xFFF1, Ofl=0.
  - out_valid exactly 17 cycles after accept; in_ready=0 for the 16 BUSY cycles.
- Back-pressure: hold out_ready=0 for 5 cycles after an OR result → Out/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND) in the same cycle → AND result next cycle, no bubble.
- Assert rst during cycle 8 of a MUL → out_valid stays 0, Out=0, Z=1. Then rerun with WIDTH=32: ADD 0xFFFFFFFF+1 → Z=1, C=1; MUL latency 33 cycles.
